// File: rtl/freq_counter_calibrator.sv
// Frequency-counter threshold calibrator: averages 2**CAL_LOG2 in-range period samples
// into compare_point_o, then demodulates bits by comparing each sample against it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i
// DISCARD | drop first (partial-window) sample, range-checked
// ACCUM   | accumulate in-range samples until 2**CAL_LOG2 accepted
// RUN     | calibrated; each sample produces a registered bit
// ERROR   | calibration failed (range or timeout); compare point kept
module freq_counter_calibrator #(
  parameter int CAL_LOG2        = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MIN_SAMPLE      = 100,
  parameter int MAX_SAMPLE      = 300,
  parameter int DEFAULT_COMPARE = 200
) (
  input  logic        clk_200M,
  input  logic        reset_n_input_freq,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        sample_valid_i,
  input  logic [15:0] sample_i,
  output logic [15:0] compare_point_o,
  output logic        busy_o,
  output logic        cal_done_o,
  output logic        error_o,
  output logic        bit_o,
  output logic        bit_valid_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DISCARD = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam int ACC_W = 16 + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** CAL_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      MIN_S    = 16'(MIN_SAMPLE);
  localparam logic [15:0]      MAX_S    = 16'(MAX_SAMPLE);
  localparam logic [15:0]      DEF_CP   = 16'(DEFAULT_COMPARE);

  logic [2:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [15:0]      r_cp;
  logic             r_busy;
  logic             r_cal_done;
  logic             r_error;
  logic             r_bit;
  logic             r_bit_valid;

  logic [2:0]       w_state_nxt;
  logic             w_in_range;
  logic             w_busy;
  logic             w_timeout;
  logic             w_final;
  logic             w_accept;
  logic             w_run_bit;
  logic [ACC_W-1:0] w_sum;

  assign w_in_range = (sample_i >= MIN_S) && (sample_i <= MAX_S);
  assign w_busy     = (r_state == S_DISCARD) || (r_state == S_ACCUM);
  // a strobe always clears the timer, so a coincident final sample wins over timeout
  assign w_timeout  = w_busy && !sample_valid_i && (r_to_cnt == TO_LAST);
  assign w_accept   = (r_state == S_ACCUM) && sample_valid_i && w_in_range;
  assign w_final    = w_accept && (r_cnt == LAST_CNT);
  assign w_sum      = r_acc + ACC_W'(sample_i);

  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) w_state_nxt = S_DISCARD;
        S_DISCARD: begin
          if (sample_valid_i) w_state_nxt = w_in_range ? S_ACCUM : S_ERROR;
          else if (w_timeout) w_state_nxt = S_ERROR;
        end
        S_ACCUM: begin
          if (sample_valid_i && !w_in_range) w_state_nxt = S_ERROR;
          else if (w_final)                  w_state_nxt = S_RUN;
          else if (w_timeout)                w_state_nxt = S_ERROR;
        end
        S_RUN, S_ERROR: if (start_i) w_state_nxt = S_DISCARD;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // bits only while staying in RUN, so abort/recalibration never leaks a strobe
  assign w_run_bit = (r_state == S_RUN) && sample_valid_i && (w_state_nxt == S_RUN);

  always_ff @(posedge clk_200M or negedge reset_n_input_freq) begin
    if (!reset_n_input_freq) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_cp        <= DEF_CP;
      r_busy      <= 1'b0;
      r_cal_done  <= 1'b0;
      r_error     <= 1'b0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == S_DISCARD) || (w_state_nxt == S_ACCUM);
      r_cal_done  <= (w_state_nxt == S_RUN);
      r_error     <= (w_state_nxt == S_ERROR);
      r_bit_valid <= w_run_bit;
      if (w_run_bit) r_bit <= (sample_i < r_cp);

      if ((w_state_nxt == S_DISCARD) && (r_state != S_DISCARD)) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_to_cnt <= '0;
      end else if (w_busy) begin
        r_to_cnt <= sample_valid_i ? '0 : r_to_cnt + 1'b1;
        if (w_accept) begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end

      if (w_final && !abort_i) r_cp <= w_sum[ACC_W-1:CAL_LOG2];
    end
  end

  assign compare_point_o = r_cp;
  assign busy_o          = r_busy;
  assign cal_done_o      = r_cal_done;
  assign error_o         = r_error;
  assign bit_o           = r_bit;
  assign bit_valid_o     = r_bit_valid;

endmodule
